// File: rtl/pwm_duty_ramp_if.sv
// pwm_duty_ramp_if: valid/ready command port carrying the target duty, the step size and the update divider
interface pwm_duty_ramp_if #(parameter int R = 10, parameter int W = 8);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [R-1:0] cmd_target;
  logic [R-1:0] cmd_step;
  logic [W-1:0] cmd_div;
  modport master (output cmd_valid, cmd_target, cmd_step, cmd_div, input cmd_ready);
  modport slave (input cmd_valid, cmd_target, cmd_step, cmd_div, output cmd_ready);
endinterface

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slew-limited duty sequencer whose duty updates land only on PWM period boundaries
module pwm_duty_ramp #(
  parameter int R = 10,
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  pwm_duty_ramp_if.slave cmd,
  output logic [R-1:0]  duty,
  output logic          busy,
  output logic          done,
  output logic          period_start
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RAMP = 1'b1;
  logic [0:0]   state;
  logic [R-1:0] p, tgt, stp, nxt;
  logic [W-1:0] dv, ivl;
  logic [R:0]   up, dn;
  assign period_start  = p == '0;
  assign cmd.cmd_ready = state == IDLE;
  assign busy          = state == RAMP;
  // one extra bit so the step can never wrap past either end of the range
  always_comb begin
    up  = {1'b0, duty} + {1'b0, stp};
    dn  = {1'b0, duty} - {1'b0, stp};
    nxt = duty < tgt ? (up > {1'b0, tgt} ? tgt : up[R-1:0])
        : duty > tgt ? ((dn[R] || dn < {1'b0, tgt}) ? tgt : dn[R-1:0])
        : duty;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      p     <= '0;
      duty  <= '0;
      tgt   <= '0;
      stp   <= '0;
      dv    <= '0;
      ivl   <= '0;
      done  <= 1'b0;
    end else begin
      p    <= p + 1'b1;
      done <= 1'b0;
      if (state == IDLE) begin
        if (cmd.cmd_valid) begin
          tgt   <= cmd.cmd_target;
          stp   <= cmd.cmd_step == '0 ? R'(1) : cmd.cmd_step;
          dv    <= cmd.cmd_div;
          ivl   <= '0;
          state <= RAMP;
        end
      end else if (&p) begin
        if (ivl != dv) ivl <= ivl + 1'b1;
        else begin
          ivl  <= '0;
          duty <= nxt;
          if (nxt == tgt) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb_pwm_duty_ramp: directed checks of ramp up/down, divider, ignored commands and async reset
module tb_pwm_duty_ramp;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] duty;
  logic       busy, done, period_start;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  pwm_duty_ramp_if #(.R(4), .W(4)) cmd_if ();
  pwm_duty_ramp #(.R(4), .W(4)) dut (
    .clk(clk), .reset_n(reset_n), .cmd(cmd_if),
    .duty(duty), .busy(busy), .done(done), .period_start(period_start)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic next_ps();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 40);
    if (!period_start) chk("ps_timeout", 0, 1);
  endtask
  task automatic send(input int t, input int s, input int d);
    next_ps();
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = 4'(t);
    cmd_if.cmd_step   = 4'(s);
    cmd_if.cmd_div    = 4'(d);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    chk("acc_busy", busy, 1);
    chk("acc_ready", cmd_if.cmd_ready, 0);
  endtask
  task automatic ramp(input string tag, input int t, input int s, input int exp[$]);
    send(t, s, 0);
    foreach (exp[i]) begin
      next_ps();
      chk({tag, "_duty"}, duty, exp[i]);
      chk({tag, "_done"}, done, i == exp.size() - 1);
    end
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_ready_end"}, cmd_if.cmd_ready, 1);
  endtask
  initial begin
    int last;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_target = '0;
    cmd_if.cmd_step   = '0;
    cmd_if.cmd_div    = '0;
    #12;
    chk("rst_duty", duty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_if.cmd_ready, 1);
    chk("rst_ps", period_start, 1);
    @(negedge clk);
    reset_n = 1'b1;
    ramp("up", 10, 3, '{3, 6, 9, 10});
    @(negedge clk);
    chk("up_done_pulse", done, 0);
    ramp("down", 1, 4, '{6, 2, 1});
    ramp("to14", 14, 13, '{14});
    ramp("nowrap", 15, 8, '{15});
    ramp("to0", 0, 15, '{0});
    send(4, 1, 2);
    last = 0;
    for (int i = 1; i <= 4; i++) begin
      next_ps();
      chk("div_hold1", duty, i - 1);
      next_ps();
      chk("div_hold2", duty, i - 1);
      next_ps();
      chk("div_duty", duty, i);
      chk("div_done", done, i == 4);
      if (i > 1) chk("div_spacing", cyc - last, 48);
      last = cyc;
    end
    ramp("step0", 2, 0, '{3, 2});
    send(10, 3, 0);
    next_ps();
    chk("ign_duty5", duty, 5);
    @(negedge clk);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_target = 4'd0;
    cmd_if.cmd_step   = 4'd15;
    #1;
    chk("ign_ready", cmd_if.cmd_ready, 0);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    next_ps();
    chk("ign_duty8", duty, 8);
    next_ps();
    chk("ign_duty10", duty, 10);
    chk("ign_done", done, 1);
    ramp("equal", 10, 5, '{10});
    send(0, 4, 0);
    next_ps();
    chk("mid_duty6", duty, 6);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_duty", duty, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cmd_if.cmd_ready, 1);
    chk("arst_done", done, 0);
    chk("arst_ps", period_start, 1);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_ps0", period_start, 1);
    @(negedge clk);
    chk("rel_ps1", period_start, 0);
    chk("rel_busy", busy, 0);
    chk("rel_duty", duty, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pwm_duty_ramp.md
# pwm_duty_ramp

Slew-limited duty-cycle sequencer that sits directly upstream of the basic PWM generator and drives its `duty` input. It accepts a target duty and step size over a valid/ready command port. It then walks `duty` toward the target by at most `step` per update, with updates aligned to PWM period boundaries. Typical uses are LED fades/breathing and soft-start of motor drives without glitches mid-period.

## Interface
- `R`, 10, duty resolution in bits; must equal the downstream PWM's `R`
- `W`, 8, width of the update-interval divider
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept a command
- `cmd_target`  in  R  final duty value
- `cmd_step`  in  R  max duty change per update; 0 is treated as 1
- `cmd_div`  in  W  update every `cmd_div+1` PWM periods
- `duty`  out  R  registered duty value, to PWM `duty`
- `busy`  out  1  ramp in progress
- `done`  out  1  one-cycle pulse when `duty` reaches the target
- `period_start`  out  1  high while the internal period counter is 0

## Operation
- Internal R-bit period counter `p` increments every clock and wraps 2^R-1 -> 0. It mirrors the downstream PWM counter, since both are reset together.
- `period_start` = (`p` == 0), combinational.
- States: IDLE and RAMP. `cmd_ready` = (state == IDLE). `busy` = (state == RAMP).
- Accept when `cmd_valid && cmd_ready`:
  - latch target, step (0 -> 1) and div
  - clear interval counter `ivl`
  - go to RAMP
- Commands presented while in RAMP are ignored; there is no queueing.
- In RAMP, at the last cycle of a period (`p` == 2^R-1):
  - if `ivl` != div: `ivl` <= `ivl`+1
  - else: `ivl` <= 0 and perform an update
- Update arithmetic uses R+1 bits, so there is no wrap-around:
  - `duty` < target: `duty` <= min(`duty`+step, target)
  - `duty` > target: `duty` <= max(`duty`-step, target)
  - `duty` == target: `duty` unchanged
- If the post-update `duty` equals the target: state -> IDLE and `done` = 1 for exactly one cycle.
- Target equal to the current duty at accept: RAMP is still entered, and `done` fires at the first update with `duty` unchanged.
- `duty` holds its value in IDLE. A new command starts from the current `duty`.

## Timing
- Reset values:
  - `duty`=0, `p`=0, `ivl`=0, state IDLE
  - `cmd_ready`=1, `busy`=0, `done`=0, `period_start`=1
- Reset is asynchronous. Asserting it mid-ramp immediately forces all of the above and aborts the ramp with no `done`.
- Command accept takes effect on the clock edge. `busy` rises and `cmd_ready` falls the following cycle.
- `duty` changes only on the edge where `p` goes 2^R-1 -> 0. The new value is therefore visible in the cycle with `period_start`=1, and the PWM never sees a mid-period change.
- First update occurs at the (`div`+1)-th period end after accept. A partial first period counts as one.
- `done` and `busy` falling occur on the same edge as the final `duty` change. `cmd_ready` is 1 in that same cycle, so back-to-back commands are possible.
- Ramp length = ceil(|target-duty0|/step) updates, or 1 update if equal.

## Test plan
All scenarios use R=4 (16-clock period) and W=4.
- **Up ramp:** `duty`=0, cmd target 10, step 3, div 0 -> `duty` goes 3, 6, 9, 10 at four successive period starts; `done` pulses once together with 10; `busy` is low afterwards.
- **Down ramp with floor:** from 10, target 1, step 4, div 0 -> 6, 2, 1. Then from 14, target 15, step 8 -> 15 with no wrap to 6.
- **Divider:** target 4, step 1, div 2 -> each increment is 48 clocks apart and lands on `period_start`. With step 0, target 2 -> increments of 1.
- **Ignored command:** `cmd_valid` with target 0 while busy ramping to 10 -> `cmd_ready`=0, ramp continues to 10 unaffected. An equal-target command -> `duty` unchanged, `done` at the first period end.
- **Reset mid-ramp:** assert `reset_n`=0 during a ramp at `duty`=6 -> `duty`=0, `busy`=0, `cmd_ready`=1 immediately with no `done`. After release, `p` restarts at 0 and `period_start`=1.
